// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the four-requester memory port arbiter.
package mem_port_arbiter_pkg;

   // Arbiter control states: wait for a request, hold the port request, pulse the result.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

   // Number of requesters sharing the port (IF, LSU, DMA, debug).
   localparam int NREQ = 4;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the environment
// (core-side requesters plus the SoC memory port).
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) ();

   logic [NREQ-1:0]         Req;
   logic [NREQ-1:0]         ReqWe;
   logic [NREQ-1:0][AW-1:0] ReqAddr;
   logic [NREQ-1:0][DW-1:0] ReqWData;
   logic [NREQ-1:0]         Ack;
   logic [NREQ-1:0]         Err;
   logic [DW-1:0]           RData;
   logic [1:0]              Sel;
   logic                    Busy;
   logic                    MemValid;
   logic                    MemReady;
   logic                    MemWe;
   logic [AW-1:0]           MemAddr;
   logic [DW-1:0]           MemWData;
   logic [DW-1:0]           MemRData;

   modport slave (
      input  Req, ReqWe, ReqAddr, ReqWData, MemReady, MemRData,
      output Ack, Err, RData, Sel, Busy, MemValid, MemWe, MemAddr, MemWData
   );

   modport master (
      output Req, ReqWe, ReqAddr, ReqWData, MemReady, MemRData,
      input  Ack, Err, RData, Sel, Busy, MemValid, MemWe, MemAddr, MemWData
   );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter_mux4to1.sv
// Plain 4-to-1 selector of W-bit words, steered by a 2-bit control index.
module mem_port_arbiter_mux4to1 #(
   parameter int W = 1
) (
   input  logic [1:0]        control,
   input  logic [3:0][W-1:0] data_in,
   output logic [W-1:0]      data_out
);

   assign data_out = data_in[control];

endmodule : mem_port_arbiter_mux4to1

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting one shared memory port to four requesters.
// The owner's payload is steered to the port through muxes indexed by Sel; the
// result comes back as a single-cycle Ack or Err pulse on the owner's bit.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   mem_port_arbiter_if.slave bus
);

   // Last wait-cycle index before the transaction is abandoned.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   arb_state_t      state_q, state_d;
   logic [1:0]      sel_q, sel_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [NREQ-1:0] err_q, err_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            busy_q, busy_d;

   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;

   // First requester found scanning ptr+1, ptr+2, ptr+3, ptr (last served is lowest).
   function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      rr_pick = ptr;
      for (int i = NREQ; i >= 1; i--) begin
         idx = ptr + 2'(i);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

   mem_port_arbiter_mux4to1 #(.W(1)) u_mux_we (
      .control  (sel_q),
      .data_in  (bus.ReqWe),
      .data_out (mem_we)
   );

   mem_port_arbiter_mux4to1 #(.W(AW)) u_mux_addr (
      .control  (sel_q),
      .data_in  (bus.ReqAddr),
      .data_out (mem_addr)
   );

   mem_port_arbiter_mux4to1 #(.W(DW)) u_mux_wdata (
      .control  (sel_q),
      .data_in  (bus.ReqWData),
      .data_out (mem_wdata)
   );

   // Next-state, grant and result computation for the IDLE/ISSUE/RESP sequence.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      ack_d   = '0;
      err_d   = '0;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (|bus.Req) begin
               sel_d   = rr_pick(bus.Req, ptr_q);
               ptr_d   = sel_d;
               cnt_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.MemReady) begin
               // Only reads refresh RData, so it keeps the last read value across writes.
               if (!mem_we) rdata_d = bus.MemRData;
               ack_d[sel_q] = 1'b1;
               state_d      = RESP;
            end else if (cnt_q == CNT_LAST) begin
               err_d[sel_q] = 1'b1;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= 2'd0;
         ptr_q   <= 2'd3;
         cnt_q   <= 8'd0;
         ack_q   <= '0;
         err_q   <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.MemValid = (state_q == ISSUE);
   assign bus.MemWe    = mem_we;
   assign bus.MemAddr  = mem_addr;
   assign bus.MemWData = mem_wdata;
   assign bus.Ack      = ack_q;
   assign bus.Err      = err_q;
   assign bus.RData    = rdata_q;
   assign bus.Sel      = sel_q;
   assign bus.Busy     = busy_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues the expected Ack/Err
// response, a monitor pops and compares whenever the arbiter pulses a result.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0]    ack;
      logic [3:0]    err;
      logic [1:0]    sel;
      bit            chk_rd;
      logic [DW-1:0] rdata;
      int            gap;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   last_resp_cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   function automatic void push(input logic [3:0] a, input logic [3:0] e, input logic [1:0] s,
                                input bit crd, input logic [DW-1:0] rd, input int gap);
      exp_t x;
      x.ack = a; x.err = e; x.sel = s; x.chk_rd = crd; x.rdata = rd; x.gap = gap;
      exp_q.push_back(x);
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: every Ack/Err pulse is matched against the oldest expectation.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && ((bus.Ack | bus.Err) != 4'b0)) begin
            if (exp_q.size() == 0) begin
               check("unexpected_resp", {56'd0, bus.Ack, bus.Err}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("resp_ack", 64'(bus.Ack), 64'(e.ack));
               check("resp_err", 64'(bus.Err), 64'(e.err));
               check("resp_sel", 64'(bus.Sel), 64'(e.sel));
               if (e.chk_rd) check("resp_rdata", 64'(bus.RData), 64'(e.rdata));
               if (e.gap > 0) check("resp_gap", 64'(cyc - last_resp_cyc), 64'(e.gap));
            end
            last_resp_cyc = cyc;
         end
      end
   end

   task automatic wait_resp(input string name, input int budget);
      bit got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if ((bus.Ack | bus.Err) != 4'b0) got = 1'b1;
      end
      check(name, 64'(got), 64'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  nv;
      bit  got;
      bus.Req      = 4'b0;
      bus.ReqWe    = 4'b0;
      bus.MemReady = 1'b0;
      bus.MemRData = '0;
      for (int i = 0; i < 4; i++) begin
         bus.ReqAddr[i]  = 32'h1000_0000 + 32'(i * 16);
         bus.ReqWData[i] = 32'h0000_00A0 + 32'(i);
      end

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_sel", 64'(bus.Sel), 64'd0);
      check("rst_ack", 64'(bus.Ack), 64'd0);
      check("rst_err", 64'(bus.Err), 64'd0);
      check("rst_rdata", 64'(bus.RData), 64'd0);
      check("rst_memvalid", 64'(bus.MemValid), 64'd0);
      check("rst_busy", 64'(bus.Busy), 64'd0);
      rst_n = 1'b1;

      // Test 1: single write request from requester 1
      bus.ReqWe    = 4'b0010;
      bus.Req      = 4'b0010;
      bus.MemReady = 1'b1;
      push(4'b0010, 4'b0000, 2'd1, 1'b0, '0, 0);
      @(negedge clk);
      check("t1_memvalid", 64'(bus.MemValid), 64'd1);
      check("t1_sel", 64'(bus.Sel), 64'd1);
      check("t1_busy", 64'(bus.Busy), 64'd1);
      check("t1_addr", 64'(bus.MemAddr), 64'h1000_0010);
      check("t1_we", 64'(bus.MemWe), 64'd1);
      check("t1_wdata", 64'(bus.MemWData), 64'hA1);
      @(negedge clk);
      check("t1_resp_memvalid", 64'(bus.MemValid), 64'd0);
      check("t1_resp_busy", 64'(bus.Busy), 64'd1);
      bus.Req   = 4'b0;
      bus.ReqWe = 4'b0;
      @(negedge clk);
      check("t1_idle_busy", 64'(bus.Busy), 64'd0);
      check("t1_idle_ack", 64'(bus.Ack), 64'd0);

      // Test 2: all four requesting, served 0,1,2,3,0 every 3 cycles
      do_reset();
      bus.MemReady = 1'b1;
      bus.Req      = 4'b1111;
      push(4'b0001, 4'b0, 2'd0, 1'b0, '0, 0);
      push(4'b0010, 4'b0, 2'd1, 1'b0, '0, 3);
      push(4'b0100, 4'b0, 2'd2, 1'b0, '0, 3);
      push(4'b1000, 4'b0, 2'd3, 1'b0, '0, 3);
      push(4'b0001, 4'b0, 2'd0, 1'b0, '0, 3);
      for (int k = 0; k < 5; k++) wait_resp("t2_resp_seen", 6);
      bus.Req = 4'b0;

      // Test 3: read from requester 2 returns DEADBEEF
      @(negedge clk);
      bus.MemRData = 32'hDEAD_BEEF;
      bus.MemReady = 1'b1;
      bus.Req      = 4'b0100;
      push(4'b0100, 4'b0, 2'd2, 1'b1, 32'hDEAD_BEEF, 0);
      wait_resp("t3_resp_seen", 6);
      bus.Req      = 4'b0;
      bus.MemRData = 32'h0;
      @(negedge clk);
      check("t3_rdata_hold", 64'(bus.RData), 64'hDEAD_BEEF);
      check("t3_busy_idle", 64'(bus.Busy), 64'd0);

      // Test 4: no MemReady, requester 3 times out after TIMEOUT cycles
      bus.MemReady = 1'b0;
      bus.Req      = 4'b1000;
      push(4'b0000, 4'b1000, 2'd3, 1'b0, '0, 0);
      nv  = 0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (bus.MemValid) nv++;
         if (bus.Err != 4'b0) got = 1'b1;
      end
      check("t4_err_seen", 64'(got), 64'd1);
      check("t4_valid_cycles", 64'(nv), 64'd4);
      check("t4_rdata_kept", 64'(bus.RData), 64'hDEAD_BEEF);
      bus.Req = 4'b0;
      @(negedge clk);

      // Test 5: requester 0 drops Req mid-ISSUE, requester 3 raised then served next
      bus.Req = 4'b0001;
      push(4'b0001, 4'b0, 2'd0, 1'b0, '0, 0);
      push(4'b1000, 4'b0, 2'd3, 1'b0, '0, 3);
      @(negedge clk);
      check("t5_memvalid", 64'(bus.MemValid), 64'd1);
      check("t5_sel", 64'(bus.Sel), 64'd0);
      bus.Req = 4'b1000;
      @(negedge clk);
      check("t5_sel_held", 64'(bus.Sel), 64'd0);
      check("t5_still_valid", 64'(bus.MemValid), 64'd1);
      bus.MemReady = 1'b1;
      wait_resp("t5_resp0_seen", 4);
      wait_resp("t5_resp3_seen", 6);
      bus.Req      = 4'b0;
      bus.MemReady = 1'b0;
      @(negedge clk);

      // Test 6: asynchronous reset while ISSUE is in progress
      bus.Req = 4'b0100;
      @(negedge clk);
      check("t6_memvalid_before", 64'(bus.MemValid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_memvalid", 64'(bus.MemValid), 64'd0);
      check("t6_rst_busy", 64'(bus.Busy), 64'd0);
      check("t6_rst_sel", 64'(bus.Sel), 64'd0);
      check("t6_rst_ack", 64'(bus.Ack), 64'd0);
      check("t6_rst_rdata", 64'(bus.RData), 64'd0);
      bus.Req      = 4'b1001;
      bus.MemReady = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      push(4'b0001, 4'b0, 2'd0, 1'b0, '0, 0);
      wait_resp("t6_resp_seen", 6);
      bus.Req = 4'b0;

      repeat (4) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mem_port_arbiter
